// File: rtl/spi_aes_slave.sv
// SPI mode-0 slave front end for the AES core.
// Receives the key, key size and data blocks, launches encrypt or decrypt,
// latches the core result and shifts it back out on a read command.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no frame; waits for synchronized cs_n low (after cs_n seen high)
// CMD    | shifting in the 8-bit command byte
// KEY    | shifting in the 256-bit key payload
// DATA   | shifting in the 128-bit data block
// READ   | shifting the held result out on miso
// SKIP   | payload finished or command refused; wait for cs_n high
module spi_aes_slave #(
    parameter int SCLK_SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sclk,
    input  logic         cs_n,
    input  logic         mosi,
    output logic         miso,
    output logic [255:0] key_out,
    output logic [1:0]   nk_out,
    output logic [127:0] block_out,
    output logic         start_enc,
    output logic         start_dec,
    input  logic [127:0] result_in,
    input  logic         done_in,
    output logic         busy,
    output logic         result_valid
);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_KEY, S_DATA, S_READ, S_SKIP} state_t;

    state_t state_q, state_d;

    logic [SCLK_SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic sclk_s, cs_s, mosi_s, sclk_prev, sclk_rise, sclk_fall;
    logic armed;
    logic [8:0]   bit_cnt;
    logic [6:0]   cmd_sr;
    logic [7:0]   cmd_byte;
    logic [254:0] key_sr;
    logic [126:0] blk_sr;
    logic [127:0] rd_sr;
    logic [127:0] result_q;
    logic pend_enc, pend_dec;
    logic key_done, data_done, read_done, enter_read;

    assign sclk_s    = sclk_sync[SCLK_SYNC_STAGES-1];
    assign cs_s      = cs_sync[SCLK_SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SCLK_SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign cmd_byte  = {cmd_sr, mosi_s};

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state decode; payload completion takes priority over a same-cycle cs_n rise.
    always_comb begin
        state_d    = state_q;
        key_done   = 1'b0;
        data_done  = 1'b0;
        read_done  = 1'b0;
        enter_read = 1'b0;
        case (state_q)
            S_IDLE: if (!cs_s && armed) state_d = S_CMD;
            S_CMD: begin
                if (sclk_rise && bit_cnt == 9'd7) begin
                    if (cmd_byte[7:2] == 6'b000100 && cmd_byte[1:0] != 2'b11) begin
                        state_d = S_KEY;
                    end else if ((cmd_byte == 8'h20 || cmd_byte == 8'h30) && !busy) begin
                        state_d = S_DATA;
                    end else if (cmd_byte == 8'h40) begin
                        state_d    = S_READ;
                        enter_read = !cs_s;
                    end else begin
                        state_d = S_SKIP;
                    end
                end
            end
            S_KEY: begin
                if (sclk_rise && bit_cnt == 9'd255) begin
                    key_done = 1'b1;
                    state_d  = S_SKIP;
                end
            end
            S_DATA: begin
                if (sclk_rise && bit_cnt == 9'd127) begin
                    data_done = 1'b1;
                    state_d   = S_SKIP;
                end
            end
            S_READ: begin
                if (sclk_rise && bit_cnt == 9'd127) begin
                    read_done = 1'b1;
                    state_d   = S_SKIP;
                end
            end
            S_SKIP:  state_d = S_SKIP;
            default: state_d = S_IDLE;
        endcase
        if (cs_s && state_q != S_IDLE) state_d = S_IDLE;
    end

    // Synchronizers, shifters, output registers and the core handshake.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sclk_sync    <= '0;
            cs_sync      <= '0;
            mosi_sync    <= '0;
            sclk_prev    <= 1'b0;
            armed        <= 1'b0;
            bit_cnt      <= '0;
            cmd_sr       <= '0;
            key_sr       <= '0;
            blk_sr       <= '0;
            rd_sr        <= '0;
            result_q     <= '0;
            pend_enc     <= 1'b0;
            pend_dec     <= 1'b0;
            miso         <= 1'b0;
            key_out      <= '0;
            nk_out       <= 2'b00;
            block_out    <= '0;
            start_enc    <= 1'b0;
            start_dec    <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SCLK_SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SCLK_SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SCLK_SYNC_STAGES-2:0], mosi};
            sclk_prev <= sclk_s;
            // A frame already under way when reset released is ignored until cs_n goes high.
            if (cs_s) armed <= 1'b1;

            start_enc <= pend_enc;
            start_dec <= pend_dec;
            pend_enc  <= 1'b0;
            pend_dec  <= 1'b0;

            if (state_d != state_q) bit_cnt <= '0;
            else if (sclk_rise)     bit_cnt <= bit_cnt + 9'd1;

            if (state_q == S_CMD  && sclk_rise) cmd_sr <= cmd_byte[6:0];
            if (state_q == S_KEY  && sclk_rise) key_sr <= {key_sr[253:0], mosi_s};
            if (state_q == S_DATA && sclk_rise) blk_sr <= {blk_sr[125:0], mosi_s};

            if (key_done) begin
                key_out <= {key_sr, mosi_s};
                nk_out  <= cmd_sr[1:0];
            end
            if (data_done) begin
                block_out <= {blk_sr, mosi_s};
                pend_enc  <= ~cmd_sr[4];
                pend_dec  <= cmd_sr[4];
            end

            // The fall right after the last command rise presents result bit 127.
            if (enter_read) begin
                rd_sr <= result_q;
                miso  <= result_q[127];
            end else if (state_q == S_READ && !read_done && !cs_s) begin
                if (sclk_fall) begin
                    miso  <= rd_sr[127];
                    rd_sr <= {rd_sr[126:0], 1'b0};
                end
            end else begin
                miso <= 1'b0;
            end

            if (read_done) result_valid <= 1'b0;
            if (pend_enc || pend_dec) begin
                busy         <= 1'b1;
                result_valid <= 1'b0;
            end else if (done_in && busy) begin
                result_q     <= result_in;
                busy         <= 1'b0;
                result_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_aes_slave.sv
// Bench for spi_aes_slave: drives SPI mode-0 frames, models the AES core
// handshake and checks outputs against expected values held in queues.
module tb_spi_aes_slave;

    localparam int HALF = 8;
    localparam logic [191:0] K192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT   = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;

    logic clk = 1'b0, rst = 1'b0, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
    logic miso, start_enc, start_dec, busy, result_valid, done_in = 1'b0;
    logic [255:0] key_out;
    logic [1:0]   nk_out;
    logic [127:0] block_out, result_in = '0;

    int n_checks = 0, n_pass = 0;
    int enc_cnt = 0, dec_cnt = 0;
    logic [127:0] start_blk = '0;
    logic [255:0] key_q[$];
    logic [127:0] blk_q[$];
    logic [127:0] res_q[$];
    logic [255:0] last_key = '0;
    logic [1:0]   last_nk = 2'b00;
    logic [127:0] last_blk = '0;

    spi_aes_slave #(.SCLK_SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
        .key_out(key_out), .nk_out(nk_out), .block_out(block_out),
        .start_enc(start_enc), .start_dec(start_dec), .result_in(result_in),
        .done_in(done_in), .busy(busy), .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    // Count start pulse cycles and note the block presented with each pulse.
    always @(negedge clk) begin
        if (start_enc) enc_cnt <= enc_cnt + 1;
        if (start_dec) dec_cnt <= dec_cnt + 1;
        if (start_enc || start_dec) start_blk <= block_out;
    end

    task automatic spi_bit(input logic b, output logic m);
        mosi = b;
        repeat (HALF) @(negedge clk);
        m = miso;
        sclk = 1'b1;
        repeat (HALF) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic spi_xfer(input logic [7:0] cmd, input logic [255:0] pay, input int nbits,
                            output logic [255:0] rd);
        logic [263:0] bits;
        logic m;
        bits = {cmd, pay};
        rd = '0;
        @(negedge clk);
        cs_n = 1'b0;
        repeat (2 * HALF) @(negedge clk);
        for (int i = 0; i < 8 + nbits; i++) begin
            spi_bit(bits[263-i], m);
            if (i >= 8) rd = {rd[254:0], m};
        end
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic core_done(input logic [127:0] r);
        result_in = r;
        done_in = 1'b1;
        @(negedge clk);
        done_in = 1'b0;
        result_in = '0;
    endtask

    task automatic test_reset();
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({miso, start_enc, start_dec, busy, result_valid} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000", {miso, start_enc, start_dec, busy, result_valid});
        else n_pass++;
        n_checks++;
        if (key_out !== 256'h0) $display("FAIL reset_key: got %h want 0", key_out); else n_pass++;
        n_checks++;
        if (nk_out !== 2'b00) $display("FAIL reset_nk: got %b want 00", nk_out); else n_pass++;
        n_checks++;
        if (block_out !== 128'h0) $display("FAIL reset_block: got %h want 0", block_out); else n_pass++;
    endtask

    task automatic test_key192();
        logic [255:0] rd, exp_k;
        int e0, d0;
        e0 = enc_cnt; d0 = dec_cnt;
        key_q.push_back({K192, 64'h0});
        spi_xfer(8'h11, {K192, 64'h0}, 256, rd);
        exp_k = key_q.pop_front();
        last_key = exp_k; last_nk = 2'b01;
        n_checks++;
        if (key_out !== exp_k) $display("FAIL key192_value: got %h want %h", key_out, exp_k); else n_pass++;
        n_checks++;
        if (nk_out !== 2'b01) $display("FAIL key192_nk: got %b want 01", nk_out); else n_pass++;
        n_checks++;
        if ((enc_cnt - e0) + (dec_cnt - d0) !== 0)
            $display("FAIL key192_no_start: got %0d pulses want 0", (enc_cnt - e0) + (dec_cnt - d0));
        else n_pass++;
    endtask

    task automatic test_data(input logic [7:0] cmd, input logic [127:0] blk, input logic [127:0] res);
        logic [255:0] rd;
        logic [127:0] exp_b;
        int e0, d0, exp_e, exp_d;
        e0 = enc_cnt; d0 = dec_cnt;
        exp_e = (cmd == 8'h20) ? 1 : 0;
        exp_d = 1 - exp_e;
        blk_q.push_back(blk);
        spi_xfer(cmd, {blk, 128'h0}, 128, rd);
        exp_b = blk_q.pop_front();
        last_blk = exp_b;
        n_checks++;
        if (block_out !== exp_b) $display("FAIL data_block: got %h want %h", block_out, exp_b); else n_pass++;
        n_checks++;
        if (enc_cnt - e0 !== exp_e || dec_cnt - d0 !== exp_d)
            $display("FAIL data_pulses: got enc %0d dec %0d want enc %0d dec %0d",
                     enc_cnt - e0, dec_cnt - d0, exp_e, exp_d);
        else n_pass++;
        n_checks++;
        if (start_blk !== exp_b) $display("FAIL data_block_at_start: got %h want %h", start_blk, exp_b); else n_pass++;
        n_checks++;
        if ({busy, result_valid} !== 2'b10)
            $display("FAIL data_busy: got busy/valid %b want 10", {busy, result_valid});
        else n_pass++;
    endtask

    task automatic test_busy_refuse();
        logic [255:0] rd;
        int e0, d0;
        e0 = enc_cnt; d0 = dec_cnt;
        spi_xfer(8'h20, {128'hfeedfacecafebeef0123456789abcdef, 128'h0}, 128, rd);
        n_checks++;
        if (block_out !== last_blk) $display("FAIL busy_block: got %h want %h", block_out, last_blk); else n_pass++;
        n_checks++;
        if ((enc_cnt - e0) + (dec_cnt - d0) !== 0 || busy !== 1'b1)
            $display("FAIL busy_refuse: got pulses %0d busy %b want 0 1", (enc_cnt - e0) + (dec_cnt - d0), busy);
        else n_pass++;
    endtask

    task automatic test_complete(input logic [127:0] res);
        res_q.push_back(res);
        core_done(res);
        n_checks++;
        if ({busy, result_valid} !== 2'b01)
            $display("FAIL complete_flags: got busy/valid %b want 01", {busy, result_valid});
        else n_pass++;
    endtask

    task automatic test_read();
        logic [255:0] rd;
        logic [127:0] exp_r;
        spi_xfer(8'h40, 256'h0, 128, rd);
        exp_r = res_q.pop_front();
        n_checks++;
        if (rd[127:0] !== exp_r) $display("FAIL read_data: got %h want %h", rd[127:0], exp_r); else n_pass++;
        n_checks++;
        if (result_valid !== 1'b0 || miso !== 1'b0)
            $display("FAIL read_after: got valid %b miso %b want 0 0", result_valid, miso);
        else n_pass++;
    endtask

    task automatic test_abort();
        logic [255:0] rd;
        int e0, d0;
        e0 = enc_cnt; d0 = dec_cnt;
        spi_xfer(8'h20, {128'h0f0e0d0c0b0a09080706050403020100, 128'h0}, 60, rd);
        n_checks++;
        if (block_out !== last_blk) $display("FAIL abort_block: got %h want %h", block_out, last_blk); else n_pass++;
        n_checks++;
        if ((enc_cnt - e0) + (dec_cnt - d0) !== 0 || busy !== 1'b0)
            $display("FAIL abort_pulse: got pulses %0d busy %b want 0 0", (enc_cnt - e0) + (dec_cnt - d0), busy);
        else n_pass++;
    endtask

    task automatic test_done_ignored();
        core_done(128'h55555555aaaaaaaa55555555aaaaaaaa);
        n_checks++;
        if ({busy, result_valid} !== 2'b00)
            $display("FAIL done_ignored: got busy/valid %b want 00", {busy, result_valid});
        else n_pass++;
        res_q.push_back(PT);
        test_read();
    endtask

    task automatic test_bad_cmds();
        logic [255:0] rd;
        spi_xfer(8'h13, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 256, rd);
        spi_xfer(8'h7F, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 256, rd);
        n_checks++;
        if (key_out !== last_key || nk_out !== last_nk)
            $display("FAIL bad_cmd_key: got %h/%b want %h/%b", key_out, nk_out, last_key, last_nk);
        else n_pass++;
        n_checks++;
        if (block_out !== last_blk) $display("FAIL bad_cmd_block: got %h want %h", block_out, last_blk); else n_pass++;
    endtask

    task automatic test_reset_mid_key();
        logic [263:0] bits;
        logic [255:0] rd;
        logic m;
        bits = {8'h12, K256};
        @(negedge clk);
        cs_n = 1'b0;
        repeat (2 * HALF) @(negedge clk);
        for (int i = 0; i < 108; i++) spi_bit(bits[263-i], m);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int i = 108; i < 264; i++) spi_bit(bits[263-i], m);
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        n_checks++;
        if (key_out !== 256'h0 || nk_out !== 2'b00 || block_out !== 128'h0)
            $display("FAIL rst_mid_regs: got key %h nk %b blk %h want all 0", key_out, nk_out, block_out);
        else n_pass++;
        n_checks++;
        if ({miso, busy, result_valid} !== 3'b000)
            $display("FAIL rst_mid_flags: got %b want 000", {miso, busy, result_valid});
        else n_pass++;
        key_q.push_back(K256);
        spi_xfer(8'h12, K256, 256, rd);
        last_key = key_q.pop_front();
        n_checks++;
        if (key_out !== last_key || nk_out !== 2'b10)
            $display("FAIL rst_then_key: got %h/%b want %h/10", key_out, nk_out, last_key);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_key192();
        test_data(8'h20, PT, CT);
        test_complete(CT);
        test_read();
        test_data(8'h30, CT, PT);
        test_busy_refuse();
        test_complete(PT);
        test_read();
        test_abort();
        test_done_ignored();
        test_bad_cmds();
        test_reset_mid_key();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_aes_slave.md
# spi_aes_slave

SPI slave front end for the AES core: receives key, key-size and data blocks from an SPI master (mode 0, MSB first), launches encryption or decryption on the core, latches the core's 128-bit result and shifts it back to the master on request. It sits between the external SPI pins and the AES top level, as the far end of the link driven by `SPI_Master`. All SPI inputs are oversampled in the system clock domain.

## Interface
- `SCLK_SYNC_STAGES`, 2, synchronizer depth for `sclk`, `cs_n`, `mosi` (≥2).
- `clk`  in  1  system clock; every flop is on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `sclk`  in  1  SPI clock from the master; asynchronous; frequency ≤ clk/8.
- `cs_n`  in  1  SPI chip select, active-low; frame boundary.
- `mosi`  in  1  master-out data.
- `miso`  out  1  slave-out data; 0 whenever no read payload is active.
- `key_out`  out  256  key register; MSB-aligned; low bits unused for Nk=4/6.
- `nk_out`  out  2  key size: 00=AES-128, 01=AES-192, 10=AES-256.
- `block_out`  out  128  data block to the core.
- `start_enc`  out  1  one-cycle pulse: begin encryption of `block_out`.
- `start_dec`  out  1  one-cycle pulse: begin decryption of `block_out`.
- `result_in`  in  128  core output.
- `done_in`  in  1  core completion; high for ≥1 cycle while `result_in` is valid.
- `busy`  out  1  operation in flight.
- `result_valid`  out  1  an unread result is held.

## Operation
- Sync: `sclk`, `cs_n` and `mosi` each pass through `SCLK_SYNC_STAGES` flops. Edges are detected on the synchronized `sclk` by comparing it with its previous value.
- Frame: `cs_n` goes low, then an 8-bit command byte, then the payload. Bits are captured on synchronized `sclk` rises, MSB first.
- Commands:
  - 0x10|nk (nk = 0..2): write key, 256-bit payload. Nk=4 and Nk=6 use only the leading 128/192 bits, but the master always sends 256.
  - 0x20: data block, 128 bits, then encrypt.
  - 0x30: data block, 128 bits, then decrypt.
  - 0x40: read result, 128 bits out on `miso`.
- FSM states: IDLE, CMD, KEY, DATA, READ, SKIP.
  - IDLE → CMD on `cs_n` low.
  - CMD → KEY, DATA or READ after 8 bits. An unknown command, nk=3, or 0x20/0x30 while `busy` goes to SKIP.
  - KEY, DATA and READ go to SKIP after their payload count.
  - Every state returns to IDLE when synchronized `cs_n` goes high.
- Shift registers are 256- and 128-bit, with a 9-bit bit counter. `key_out`, `nk_out` and `block_out` update only on payload completion, never bit-by-bit.
- Abort: `cs_n` high mid-payload discards the partial shift. No output register changes and no start pulse is issued.
- Start: after DATA completes, `block_out` is loaded. On the next cycle `start_enc` or `start_dec` pulses once, `busy` sets and `result_valid` clears.
- Completion: when `done_in` is high and `busy` is set, `result_in` is latched into the result register, `busy` clears and `result_valid` sets. `done_in` while not busy is ignored.
- Read: the result register is loaded into the miso shifter on CMD→READ. `miso` presents the bit on each synchronized `sclk` fall, with the first bit valid before the first payload rise. After 128 bits `result_valid` clears.
- A read with `result_valid` low shifts out the last result, or zeros after reset.
- A key write during `busy` is accepted. The core is responsible for latching the key at start.

## Timing
- Reset values: `miso`=0, `key_out`=0, `nk_out`=00, `block_out`=0, `start_enc`=0, `start_dec`=0, `busy`=0, `result_valid`=0, FSM=IDLE.
- Capture latency: a `mosi` bit is sampled 3 clk after the `sclk` pin rises (2 sync + 1 edge detect).
- Start pulse: `start_*` is high exactly 1 clk, 1 clk after `block_out` updates, which is 4 clk after the 136th `sclk` rise.
- Result: `busy` and `result_valid` change in the cycle after `done_in` is sampled.
- Simultaneous events: `cs_n` rising on the same cycle as the last payload bit counts as complete. `done_in` coinciding with a new start cannot occur, because starts are refused while busy.
- `rst` low mid-frame returns to IDLE and clears everything. The frame is ignored until `cs_n` is seen high.

## Test plan
- Key 0x000102…1617 (192-bit, zero-padded), cmd 0x11 -> `nk_out`=01, `key_out`[255:64] = key, no start pulse.
- Cmd 0x20 + 0x00112233445566778899aabbccddeeff -> `block_out` = that value, one `start_enc` pulse, `busy`=1. Model `done_in` with 0xdda97ca4864cdfe06eaf70a0ec0d7191 -> `result_valid`=1.
- Cmd 0x40 -> `miso` returns 0xdda97ca4864cdfe06eaf70a0ec0d7191 MSB first, and `result_valid`=0 after 128 bits.
- Cmd 0x30 + 0xdda97ca4…7191 -> one `start_dec` pulse; readback of the modelled result gives 0x00112233445566778899aabbccddeeff.
- `cs_n` raised after 60 data bits -> `block_out` unchanged, no pulse. Cmd 0x20 while `busy` -> ignored.
- Cmd 0x13 and cmd 0x7F -> no register change. Reset asserted mid-key-payload -> all outputs at reset values.
